// File: rtl/rf_pkg.sv
// Shared defaults and types for the pipelined integer register file.
package rf_pkg;

    localparam int unsigned RF_A_WIDTH  = 5;
    localparam int unsigned RF_D_WIDTH  = 32;
    localparam int unsigned RF_NRD      = 2;
    localparam int unsigned RF_TRIG_REG = 9;
    localparam int unsigned RF_OUT_REG  = 10;

    typedef logic [RF_A_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_D_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for RAW hazard detection against in-flight writebacks.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned A_WIDTH = RF_A_WIDTH,
    parameter int unsigned NRD     = RF_NRD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iss_valid,
    input  logic [A_WIDTH-1:0]            iss_rd,
    input  logic                          we,
    input  logic [A_WIDTH-1:0]            wad,
    input  logic [NRD-1:0][A_WIDTH-1:0]   rad,
    output logic [NRD-1:0]                hazard,
    output logic [A_WIDTH:0]              busy_cnt
);

    localparam int unsigned DEPTH = 2**A_WIDTH;
    localparam int unsigned CW    = A_WIDTH + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Issue is applied after writeback so a new producer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (we && (wad != '0)) begin
            busy_d[wad] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // A value arriving on the bypass this cycle is not a hazard.
    always_comb begin
        hazard = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            hazard[p] = (rad[p] != '0) && busy_q[rad[p]] && !(we && (wad == rad[p]));
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: rtl/rf_pipe.sv
// Integer register file with write bypass, hardwired x0, trigger/debug registers
// and a busy scoreboard for decode-stage hazard detection.
module rf_pipe
    import rf_pkg::*;
#(
    parameter int unsigned A_WIDTH  = RF_A_WIDTH,
    parameter int unsigned D_WIDTH  = RF_D_WIDTH,
    parameter int unsigned NRD      = RF_NRD,
    parameter int unsigned TRIG_REG = RF_TRIG_REG,
    parameter int unsigned OUT_REG  = RF_OUT_REG
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trigger,
    input  logic                          we,
    input  logic [A_WIDTH-1:0]            wad,
    input  logic [D_WIDTH-1:0]            wd,
    input  logic                          iss_valid,
    input  logic [A_WIDTH-1:0]            iss_rd,
    input  logic [NRD-1:0][A_WIDTH-1:0]   rad,
    output logic [NRD-1:0][D_WIDTH-1:0]   rd,
    output logic [NRD-1:0]                hazard,
    output logic [A_WIDTH:0]              busy_cnt,
    output logic [D_WIDTH-1:0]            a0
);

    localparam int unsigned        DEPTH  = 2**A_WIDTH;
    localparam logic [A_WIDTH-1:0] TRIG_A = A_WIDTH'(TRIG_REG);
    localparam logic [A_WIDTH-1:0] OUT_A  = A_WIDTH'(OUT_REG);

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic               wr_en;

    assign wr_en = we && (wad != '0) && (wad != TRIG_A);

    // Entry 0 only ever sees reset; the trigger register overrides any write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wad] <= wd;
            end
            mem_q[TRIG_A] <= D_WIDTH'(trigger);
        end
    end

    always_comb begin
        rd = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            if (rad[p] == '0) begin
                rd[p] = '0;
            end else if (we && (wad == rad[p]) && (wad != TRIG_A)) begin
                rd[p] = wd;
            end else begin
                rd[p] = mem_q[rad[p]];
            end
        end
    end

    assign a0 = mem_q[OUT_A];

    rf_scoreboard #(
        .A_WIDTH (A_WIDTH),
        .NRD     (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .wad       (wad),
        .rad       (rad),
        .hazard    (hazard),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_rf_pipe.sv
// Scoreboard bench for rf_pipe: directed stimulus queues expectations, a monitor compares.
module tb_rf_pipe;
    import rf_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            trigger = 1'b0;
    logic            we = 1'b0;
    logic [4:0]      wad = '0;
    rf_data_t        wd = '0;
    logic            iss_valid = 1'b0;
    logic [4:0]      iss_rd = '0;
    logic [1:0][4:0] rad = '0;
    logic [1:0][31:0] rd;
    logic [1:0]      hazard;
    logic [5:0]      busy_cnt;
    rf_data_t        a0;

    localparam int unsigned M_RD0 = 1, M_RD1 = 2, M_HAZ = 4, M_CNT = 8, M_A0 = 16;
    localparam int unsigned M_ALL = 31;

    typedef struct {
        int unsigned mask;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  haz;
        logic [5:0]  cnt;
        logic [31:0] a0;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    rf_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .we        (we),
        .wad       (wad),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rad       (rad),
        .rd        (rd),
        .hazard    (hazard),
        .busy_cnt  (busy_cnt),
        .a0        (a0)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge and queue what should be seen.
    task automatic cyc(input logic r, input logic t, input logic w, input logic [4:0] wa,
                       input logic [31:0] wdat, input logic iv, input logic [4:0] ir,
                       input logic [4:0] r0, input logic [4:0] r1, input string nm,
                       input int unsigned m, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] eh, input logic [5:0] ec, input logic [31:0] ea);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; trigger = t; we = w; wad = wa; wd = wdat;
        iss_valid = iv; iss_rd = ir; rad[0] = r0; rad[1] = r1;
        e.mask = m; e.rd0 = e0; e.rd1 = e1; e.haz = eh; e.cnt = ec; e.a0 = ea;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: samples just before the rising edge, after inputs have settled.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ((e.mask & M_RD0) != 0) cmp(nm, "rd0", rd[0], e.rd0);
                if ((e.mask & M_RD1) != 0) cmp(nm, "rd1", rd[1], e.rd1);
                if ((e.mask & M_HAZ) != 0) cmp(nm, "hazard", 32'(hazard), 32'(e.haz));
                if ((e.mask & M_CNT) != 0) cmp(nm, "busy_cnt", 32'(busy_cnt), 32'(e.cnt));
                if ((e.mask & M_A0) != 0)  cmp(nm, "a0", a0, e.a0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //   rst t  we wad  wd            iv ird r0  r1  name          mask   rd0           rd1          haz   cnt ea
        cyc(1, 0, 0, 0, 32'h0,        0, 0, 1, 2, "in_reset",  M_ALL, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 0, 32'h0, 0, 0, 5'(i), 5'(31 - i), "read_zero", M_ALL, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        end

        // Bypass on write cycle, stored value afterwards; x0 ignores writes.
        cyc(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, "bypass",     M_ALL, 32'hDEADBEEF, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 5, 0, "stored",     M_ALL, 32'hDEADBEEF, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 5, "x0_write",   M_ALL, 32'h0, 32'hDEADBEEF, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, "x0_after",   M_RD0 | M_RD1, 32'h0, 32'h0, 2'b00, 0, 32'h0);

        // Trigger register wins over an architectural write and is never bypassed.
        cyc(0, 1, 1, 9, 32'h1234,     0, 0, 9, 0, "trig_wr",    M_RD0 | M_RD1, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 9, 0, "trig_one",   M_RD0, 32'h1, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 9, 0, "trig_zero",  M_RD0, 32'h0, 32'h0, 2'b00, 0, 32'h0);

        // Debug output mirrors register 10.
        cyc(0, 0, 1, 10, 32'hA5A5A5A5, 0, 0, 10, 0, "a0_wr",    M_RD0 | M_A0, 32'hA5A5A5A5, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 10, 0, "a0_rd",     M_RD0, 32'hA5A5A5A5, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 10, 0, "a0_out",    M_A0, 32'h0, 32'h0, 2'b00, 0, 32'hA5A5A5A5);

        // RAW hazard: issue 7, read it, then writeback with bypass.
        cyc(0, 0, 0, 0, 32'h0,        1, 7, 7, 7, "iss7_same",  M_HAZ | M_CNT, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 7, 7, "haz7",       M_HAZ | M_CNT, 32'h0, 32'h0, 2'b11, 1, 32'h0);
        cyc(0, 0, 1, 7, 32'h55,       0, 0, 7, 0, "wb7",        M_RD0 | M_HAZ | M_CNT, 32'h55, 32'h0, 2'b00, 1, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 7, 0, "wb7_after",  M_ALL, 32'h55, 32'h0, 2'b00, 0, 32'hA5A5A5A5);

        // Same-cycle issue and writeback: set wins; WAW issue keeps the count.
        cyc(0, 0, 0, 0, 32'h0,        1, 3, 3, 0, "iss3",       M_CNT, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 1, 3, 32'h33,       1, 3, 3, 0, "iss_wb3",    M_RD0 | M_HAZ | M_CNT, 32'h33, 32'h0, 2'b00, 1, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 3, 0, "still3",     M_RD0 | M_HAZ | M_CNT, 32'h33, 32'h0, 2'b01, 1, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        1, 3, 3, 3, "waw3",       M_HAZ | M_CNT, 32'h0, 32'h0, 2'b11, 1, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 0, 3, "waw3_cnt",   M_HAZ | M_CNT, 32'h0, 32'h0, 2'b10, 1, 32'h0);
        cyc(0, 0, 1, 3, 32'h99,       0, 0, 0, 0, "wb3",        M_CNT, 32'h0, 32'h0, 2'b00, 1, 32'h0);
        cyc(0, 0, 1, 12, 32'h77,      0, 0, 3, 0, "wb_nonbusy", M_RD0 | M_HAZ | M_CNT, 32'h99, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 12, 3, "rd12",      M_ALL, 32'h77, 32'h99, 2'b00, 0, 32'hA5A5A5A5);

        // Fill three busy bits, then assert reset between edges.
        cyc(0, 0, 0, 0, 32'h0,        1, 1, 0, 0, "iss1",       M_CNT, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        1, 2, 0, 0, "iss2",       M_CNT, 32'h0, 32'h0, 2'b00, 1, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        1, 3, 0, 0, "iss3b",      M_CNT, 32'h0, 32'h0, 2'b00, 2, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 1, 2, "busy3",      M_HAZ | M_CNT, 32'h0, 32'h0, 2'b11, 3, 32'h0);
        cyc(1, 1, 1, 5, 32'hCAFE,     1, 4, 1, 5, "async_rst",  M_ALL, 32'h0, 32'hCAFE, 2'b00, 0, 32'h0);
        cyc(1, 1, 0, 0, 32'h0,        0, 0, 5, 12, "rst_hold",  M_ALL, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 5, 9, "post_rst",   M_ALL, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 0, 4, 9, "post_rst2",  M_ALL, 32'h0, 32'h0, 2'b00, 0, 32'h0);

        repeat (3) @(negedge clk);
        #6;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
